// File: rtl/ictlb_assoc.sv
// Fully associative instruction L1 TLB: lookup, L2 miss fill, snoop invalidation, evict notify.
// Optional prefetch request port enabled by defining ICTLB_PREFETCH_EN.
module ictlb_assoc #(
  parameter  int ENTRIES = 16,
  parameter  int VPN_W   = 20,
  parameter  int PPN_W   = 20,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coretoictlb_pc_valid,
  output logic             coretoictlb_pc_retry,
  input  logic [VPN_W-1:0] coretoictlb_pc_vpn,
  output logic             l1tlbtol1_fwd_valid,
  input  logic             l1tlbtol1_fwd_retry,
  output logic [PPN_W-1:0] l1tlbtol1_fwd_ppn,
  output logic [IDX_W-1:0] l1tlbtol1_fwd_idx,
  output logic             l1tlbtol1_cmd_valid,
  input  logic             l1tlbtol1_cmd_retry,
  output logic [IDX_W-1:0] l1tlbtol1_cmd_idx,
  input  logic             l2tlbtol1tlb_snoop_valid,
  output logic             l2tlbtol1tlb_snoop_retry,
  input  logic [VPN_W-1:0] l2tlbtol1tlb_snoop_vpn,
  input  logic             l2tlbtol1tlb_ack_valid,
  output logic             l2tlbtol1tlb_ack_retry,
  input  logic [PPN_W-1:0] l2tlbtol1tlb_ack_ppn,
  output logic             l1tlbtol2tlb_req_valid,
  input  logic             l1tlbtol2tlb_req_retry,
  output logic [VPN_W-1:0] l1tlbtol2tlb_req_vpn,
  output logic             l1tlbtol2tlb_sack_valid,
  input  logic             l1tlbtol2tlb_sack_retry
`ifdef ICTLB_PREFETCH_EN
  ,
  input  logic             pfetol1tlb_req_valid,
  output logic             pfetol1tlb_req_retry,
  input  logic [VPN_W-1:0] pfetol1tlb_req_vpn
`endif
);

  typedef enum logic [2:0] {IDLE, RESP, MREQ, MWAIT, SCMD, SACK} state_t;

  state_t                        state;
  state_t                        ret_state;
  logic [ENTRIES-1:0]            vld;
  logic [ENTRIES-1:0][VPN_W-1:0] vpn_tab;
  logic [ENTRIES-1:0][PPN_W-1:0] ppn_tab;
  logic [IDX_W-1:0]              rr_ptr;

  logic             pc_hit, snp_hit, free_any;
  logic [IDX_W-1:0] pc_idx, snp_idx, free_idx, victim;
  logic             pc_take, snp_take, fill;

`ifdef ICTLB_PREFETCH_EN
  logic pf_hit, pf_take, pf_fill;
`endif

  // Descending scan so the last write leaves the lowest free index.
  always_comb begin
    pc_hit   = 1'b0;
    pc_idx   = '0;
    snp_hit  = 1'b0;
    snp_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
`ifdef ICTLB_PREFETCH_EN
    pf_hit   = 1'b0;
`endif
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vld[i] && vpn_tab[i] == coretoictlb_pc_vpn) begin
        pc_hit = 1'b1;
        pc_idx = IDX_W'(i);
      end
      if (vld[i] && vpn_tab[i] == l2tlbtol1tlb_snoop_vpn) begin
        snp_hit = 1'b1;
        snp_idx = IDX_W'(i);
      end
`ifdef ICTLB_PREFETCH_EN
      if (vld[i] && vpn_tab[i] == pfetol1tlb_req_vpn) pf_hit = 1'b1;
`endif
      if (!vld[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign victim = free_any ? free_idx : rr_ptr;

  assign coretoictlb_pc_retry     = reset || state != IDLE || l2tlbtol1tlb_snoop_valid;
  assign l2tlbtol1tlb_snoop_retry = reset || !(state == IDLE || state == MWAIT);
  assign l2tlbtol1tlb_ack_retry   = reset || state != MWAIT || l2tlbtol1tlb_snoop_valid;

  assign pc_take  = coretoictlb_pc_valid && !coretoictlb_pc_retry;
  assign snp_take = l2tlbtol1tlb_snoop_valid && !l2tlbtol1tlb_snoop_retry;
  assign fill     = l2tlbtol1tlb_ack_valid && !l2tlbtol1tlb_ack_retry;

`ifdef ICTLB_PREFETCH_EN
  assign pfetol1tlb_req_retry = reset || state != IDLE || coretoictlb_pc_valid ||
                                l2tlbtol1tlb_snoop_valid;
  assign pf_take = pfetol1tlb_req_valid && !pfetol1tlb_req_retry;
`endif

  always_ff @(posedge clk) begin
    if (fill) begin
      vpn_tab[victim] <= l1tlbtol2tlb_req_vpn;
      ppn_tab[victim] <= l2tlbtol1tlb_ack_ppn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      ret_state               <= IDLE;
      vld                     <= '0;
      rr_ptr                  <= '0;
      l1tlbtol1_fwd_valid     <= 1'b0;
      l1tlbtol1_fwd_ppn       <= '0;
      l1tlbtol1_fwd_idx       <= '0;
      l1tlbtol1_cmd_valid     <= 1'b0;
      l1tlbtol1_cmd_idx       <= '0;
      l1tlbtol2tlb_req_valid  <= 1'b0;
      l1tlbtol2tlb_req_vpn    <= '0;
      l1tlbtol2tlb_sack_valid <= 1'b0;
`ifdef ICTLB_PREFETCH_EN
      pf_fill                 <= 1'b0;
`endif
    end else if (snp_take) begin
      ret_state <= state;
      if (snp_hit) begin
        vld[snp_idx]        <= 1'b0;
        l1tlbtol1_cmd_valid <= 1'b1;
        l1tlbtol1_cmd_idx   <= snp_idx;
        state               <= SCMD;
      end else begin
        l1tlbtol2tlb_sack_valid <= 1'b1;
        state                   <= SACK;
      end
    end else begin
      case (state)
        IDLE: begin
          if (pc_take) begin
            if (pc_hit) begin
              l1tlbtol1_fwd_valid <= 1'b1;
              l1tlbtol1_fwd_ppn   <= ppn_tab[pc_idx];
              l1tlbtol1_fwd_idx   <= pc_idx;
              state               <= RESP;
            end else begin
              l1tlbtol2tlb_req_valid <= 1'b1;
              l1tlbtol2tlb_req_vpn   <= coretoictlb_pc_vpn;
              state                  <= MREQ;
            end
`ifdef ICTLB_PREFETCH_EN
            pf_fill <= 1'b0;
          end else if (pf_take) begin
            // Prefetch hits are dropped; misses fill silently.
            if (!pf_hit) begin
              l1tlbtol2tlb_req_valid <= 1'b1;
              l1tlbtol2tlb_req_vpn   <= pfetol1tlb_req_vpn;
              pf_fill                <= 1'b1;
              state                  <= MREQ;
            end
`endif
          end
        end
        RESP: begin
          if (l1tlbtol1_fwd_valid && !l1tlbtol1_fwd_retry) l1tlbtol1_fwd_valid <= 1'b0;
          if (l1tlbtol1_cmd_valid && !l1tlbtol1_cmd_retry) l1tlbtol1_cmd_valid <= 1'b0;
          if ((!l1tlbtol1_fwd_valid || !l1tlbtol1_fwd_retry) &&
              (!l1tlbtol1_cmd_valid || !l1tlbtol1_cmd_retry))
            state <= IDLE;
        end
        MREQ: begin
          if (!l1tlbtol2tlb_req_retry) begin
            l1tlbtol2tlb_req_valid <= 1'b0;
            state                  <= MWAIT;
          end
        end
        MWAIT: begin
          if (fill) begin
`ifdef ICTLB_PREFETCH_EN
            l1tlbtol1_fwd_valid <= !pf_fill;
`else
            l1tlbtol1_fwd_valid <= 1'b1;
`endif
            l1tlbtol1_fwd_ppn   <= l2tlbtol1tlb_ack_ppn;
            l1tlbtol1_fwd_idx   <= victim;
            if (vld[victim]) begin
              l1tlbtol1_cmd_valid <= 1'b1;
              l1tlbtol1_cmd_idx   <= victim;
            end
            vld[victim] <= 1'b1;
            if (!free_any) rr_ptr <= rr_ptr + IDX_W'(1);
            state <= RESP;
          end
        end
        SCMD: begin
          if (!l1tlbtol1_cmd_retry) begin
            l1tlbtol1_cmd_valid     <= 1'b0;
            l1tlbtol2tlb_sack_valid <= 1'b1;
            state                   <= SACK;
          end
        end
        SACK: begin
          if (!l1tlbtol2tlb_sack_retry) begin
            l1tlbtol2tlb_sack_valid <= 1'b0;
            state                   <= ret_state;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ictlb_assoc.sv
// Bench for ictlb_assoc: vector table of lookups plus hand sequences for snoop, stall and reset.
module tb_ictlb_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_valid, pc_retry;
  logic [19:0] pc_vpn;
  logic        fwd_valid, fwd_retry;
  logic [19:0] fwd_ppn;
  logic [3:0]  fwd_idx;
  logic        cmd_valid, cmd_retry;
  logic [3:0]  cmd_idx;
  logic        snoop_valid, snoop_retry;
  logic [19:0] snoop_vpn;
  logic        ack_valid, ack_retry;
  logic [19:0] ack_ppn;
  logic        req_valid, req_retry;
  logic [19:0] req_vpn;
  logic        sack_valid, sack_retry;

  always #5 clk = ~clk;

  ictlb_assoc dut (
    .clk(clk), .reset(reset),
    .coretoictlb_pc_valid(pc_valid), .coretoictlb_pc_retry(pc_retry), .coretoictlb_pc_vpn(pc_vpn),
    .l1tlbtol1_fwd_valid(fwd_valid), .l1tlbtol1_fwd_retry(fwd_retry),
    .l1tlbtol1_fwd_ppn(fwd_ppn), .l1tlbtol1_fwd_idx(fwd_idx),
    .l1tlbtol1_cmd_valid(cmd_valid), .l1tlbtol1_cmd_retry(cmd_retry), .l1tlbtol1_cmd_idx(cmd_idx),
    .l2tlbtol1tlb_snoop_valid(snoop_valid), .l2tlbtol1tlb_snoop_retry(snoop_retry),
    .l2tlbtol1tlb_snoop_vpn(snoop_vpn),
    .l2tlbtol1tlb_ack_valid(ack_valid), .l2tlbtol1tlb_ack_retry(ack_retry),
    .l2tlbtol1tlb_ack_ppn(ack_ppn),
    .l1tlbtol2tlb_req_valid(req_valid), .l1tlbtol2tlb_req_retry(req_retry),
    .l1tlbtol2tlb_req_vpn(req_vpn),
    .l1tlbtol2tlb_sack_valid(sack_valid), .l1tlbtol2tlb_sack_retry(sack_retry)
  );

  typedef struct {
    logic [19:0] vpn;
    bit          hit;
    logic [19:0] ppn;
    logic [3:0]  idx;
    bit          cmd;
    logic [3:0]  cmd_idx;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fwd_q[$];
  logic [31:0] cmd_q[$];
  logic [31:0] req_q[$];
  int          sack_exp = 0;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [19:0] vpn, input bit hit, input logic [19:0] ppn,
                              input logic [3:0] idx, input bit cmd, input logic [3:0] cidx);
    vec_t v;
    v.vpn = vpn; v.hit = hit; v.ppn = ppn; v.idx = idx; v.cmd = cmd; v.cmd_idx = cidx;
    return v;
  endfunction

  // Scoreboard: every transfer on an output channel pops and compares one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (fwd_valid && !fwd_retry) begin
        chk("fwd_expected", 32'(fwd_q.size() != 0), 1);
        if (fwd_q.size() != 0) chk("fwd_ppn_idx", {8'h0, fwd_ppn, fwd_idx}, fwd_q.pop_front());
      end
      if (cmd_valid && !cmd_retry) begin
        chk("cmd_expected", 32'(cmd_q.size() != 0), 1);
        if (cmd_q.size() != 0) chk("cmd_idx", {28'h0, cmd_idx}, cmd_q.pop_front());
      end
      if (req_valid && !req_retry) begin
        chk("req_expected", 32'(req_q.size() != 0), 1);
        if (req_q.size() != 0) chk("req_vpn", {12'h0, req_vpn}, req_q.pop_front());
      end
      if (sack_valid && !sack_retry) begin
        chk("sack_expected", 32'(sack_exp > 0), 1);
        if (sack_exp > 0) sack_exp--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    return fwd_q.size() + cmd_q.size() + req_q.size() + sack_exp;
  endfunction

  task automatic drain();
    for (int n = 0; n < 100 && pending() != 0; n++) tick();
    chk("drain_pending", 32'(pending()), 0);
  endtask

  task automatic send_pc(input logic [19:0] v);
    bit acc = 0;
    pc_vpn = v;
    pc_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      #1;
      acc = !pc_retry;
      @(posedge clk);
      #1;
    end
    pc_valid = 1'b0;
    chk("pc_accept", 32'(acc), 1);
  endtask

  task automatic send_snoop(input logic [19:0] v);
    bit acc = 0;
    snoop_vpn = v;
    snoop_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      #1;
      acc = !snoop_retry;
      @(posedge clk);
      #1;
    end
    snoop_valid = 1'b0;
    chk("snoop_accept", 32'(acc), 1);
  endtask

  task automatic send_ack(input logic [19:0] p);
    bit acc = 0;
    ack_ppn = p;
    ack_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      #1;
      acc = !ack_retry;
      @(posedge clk);
      #1;
    end
    ack_valid = 1'b0;
    chk("ack_accept", 32'(acc), 1);
  endtask

  task automatic lookup(input vec_t t);
    if (!t.hit) req_q.push_back({12'h0, t.vpn});
    fwd_q.push_back({8'h0, t.ppn, t.idx});
    if (t.cmd) cmd_q.push_back({28'h0, t.cmd_idx});
    send_pc(t.vpn);
    if (t.hit) begin
      chk("hit_latency", 32'(fwd_valid), 1);
    end else begin
      chk("miss_no_fwd", 32'(fwd_valid), 0);
      send_ack(t.ppn);
      chk("fill_latency", 32'(fwd_valid), 1);
    end
    drain();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_fwd_valid"}, 32'(fwd_valid), 0);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    chk({tag, "_req_valid"}, 32'(req_valid), 0);
    chk({tag, "_sack_valid"}, 32'(sack_valid), 0);
    chk({tag, "_retries"}, {29'h0, pc_retry, snoop_retry, ack_retry}, 32'h7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(20'(i), 0, 20'h80000 | 20'(i), 4'(i), 0, 4'h0));
    tbl.push_back(mk(20'd16, 0, 20'h90016, 4'd0, 1, 4'd0));
    tbl.push_back(mk(20'd17, 0, 20'h90017, 4'd1, 1, 4'd1));
    tbl.push_back(mk(20'd5,  1, 20'h80005, 4'd5, 0, 4'h0));
    tbl.push_back(mk(20'd16, 1, 20'h90016, 4'd0, 0, 4'h0));
    tbl.push_back(mk(20'd0,  0, 20'hA0000, 4'd2, 1, 4'd2));

    reset = 1'b1;
    pc_valid = 0; pc_vpn = 0; snoop_valid = 0; snoop_vpn = 0; ack_valid = 0; ack_ppn = 0;
    fwd_retry = 0; cmd_retry = 0; req_retry = 0; sack_retry = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    chk("reset_payload", {fwd_ppn, fwd_idx, cmd_idx}, 32'h0);
    chk("reset_req_vpn", {12'h0, req_vpn}, 32'h0);
    reset = 1'b0;
    tick();

    // First miss fills idx 0, then the same VPN hits with no L2 request.
    lookup(mk(20'h12345, 0, 20'hABCDE, 4'd0, 0, 4'h0));
    lookup(mk(20'h12345, 1, 20'hABCDE, 4'd0, 0, 4'h0));

    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    foreach (tbl[i]) lookup(tbl[i]);

    // Snoop of a resident VPN, refill into the freed slot, snoop of a non-resident VPN.
    cmd_q.push_back(32'd3);
    sack_exp++;
    send_snoop(20'd3);
    drain();
    lookup(mk(20'd3, 0, 20'hB0003, 4'd3, 0, 4'h0));
    sack_exp++;
    send_snoop(20'h77777);
    drain();

    // Snoop serviced while waiting for the fill; the freed idx 5 becomes the victim.
    req_q.push_back(32'h55555);
    send_pc(20'h55555);
    cmd_q.push_back(32'd5);
    sack_exp++;
    send_snoop(20'd5);
    drain();
    fwd_q.push_back({8'h0, 20'hBEEF0, 4'd5});
    send_ack(20'hBEEF0);
    chk("mwait_fill_latency", 32'(fwd_valid), 1);
    drain();

    // Reset during MWAIT abandons the miss and flushes all entries.
    req_q.push_back(32'h66666);
    send_pc(20'h66666);
    drain();
    reset = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    tick();
    lookup(mk(20'd10, 0, 20'h0A0A0, 4'd0, 0, 4'h0));

    // Simultaneous snoop and pc: snoop wins, pc is retried then served.
    snoop_vpn = 20'h99999;
    snoop_valid = 1'b1;
    pc_vpn = 20'd10;
    pc_valid = 1'b1;
    #1;
    chk("snoop_wins_pc_retry", 32'(pc_retry), 1);
    chk("snoop_taken_in_idle", 32'(snoop_retry), 0);
    sack_exp++;
    fwd_q.push_back({8'h0, 20'h0A0A0, 4'd0});
    tick();
    snoop_valid = 1'b0;
    send_pc(20'd10);
    chk("hit_after_snoop", 32'(fwd_valid), 1);
    drain();

    // L1 stalls the hit response for five cycles.
    fwd_retry = 1'b1;
    fwd_q.push_back({8'h0, 20'h0A0A0, 4'd0});
    send_pc(20'd10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_fwd_valid", 32'(fwd_valid), 1);
      chk("stall_fwd_payload", {8'h0, fwd_ppn, fwd_idx}, {8'h0, 20'h0A0A0, 4'd0});
      chk("stall_pc_retry", 32'(pc_retry), 1);
      tick();
    end
    fwd_retry = 1'b0;
    drain();
    tick();
    chk("idle_after_stall", 32'(pc_retry), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ictlb_assoc.md
Name: ictlb_assoc

Overview:
- Parametrised, fully associative instruction L1 TLB. Sits between the core fetch PC port, the L1 I-cache fwd/cmd ports and the L2 TLB.
- Translates VPN to PPN and returns the result plus the TLB entry index to the L1.
- On a miss it fetches the mapping from the L2 TLB and fills an entry. It services L2 snoop invalidations and notifies the L1 of evicted or invalidated indices.

Parameters:
- ENTRIES, 16, number of TLB entries (power of 2, >=2).
- VPN_W, 20, virtual page number width.
- PPN_W, 20, physical page number width.
- IDX_W, $clog2(ENTRIES), entry index width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- coretoictlb_pc_valid  in  1  core lookup request
- coretoictlb_pc_retry  out  1  backpressure to core
- coretoictlb_pc_vpn  in  VPN_W  lookup VPN
- l1tlbtol1_fwd_valid  out  1  translation to L1
- l1tlbtol1_fwd_retry  in  1  L1 backpressure
- l1tlbtol1_fwd_ppn  out  PPN_W  translated PPN
- l1tlbtol1_fwd_idx  out  IDX_W  entry index holding the translation
- l1tlbtol1_cmd_valid  out  1  index-gone notification
- l1tlbtol1_cmd_retry  in  1  L1 backpressure
- l1tlbtol1_cmd_idx  out  IDX_W  invalidated or evicted index
- l2tlbtol1tlb_snoop_valid  in  1  L2 invalidate request
- l2tlbtol1tlb_snoop_retry  out  1
- l2tlbtol1tlb_snoop_vpn  in  VPN_W
- l2tlbtol1tlb_ack_valid  in  1  miss fill response
- l2tlbtol1tlb_ack_retry  out  1
- l2tlbtol1tlb_ack_ppn  in  PPN_W
- l1tlbtol2tlb_req_valid  out  1  miss request
- l1tlbtol2tlb_req_retry  in  1
- l1tlbtol2tlb_req_vpn  out  VPN_W
- l1tlbtol2tlb_sack_valid  out  1  snoop completion
- l1tlbtol2tlb_sack_retry  in  1

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, port name reset.
- Handshake rule (all channels):
  - A transfer occurs on a cycle with valid=1 and retry=0.
  - A sender holds valid and payload stable until the transfer. valid never drops before the transfer.
- State at reset:
  - All entry valid bits 0. Round-robin pointer 0. FSM in IDLE.
  - All *_valid outputs 0. All payload outputs 0.
  - pc_retry, snoop_retry and ack_retry are 1 while reset is high.
- FSM states: IDLE, RESP, MREQ, MWAIT, SCMD, SACK.
- IDLE:
  - pc_retry=0 and snoop_retry=0.
  - If snoop and pc are valid in the same cycle, the snoop wins and pc_retry=1 that cycle.
  - An accepted pc lookup compares the VPN against all valid entries in the same cycle.
  - Hit: latch PPN and index, go to RESP. fwd_valid=1 the next cycle (1-cycle latency).
  - Miss: latch VPN, go to MREQ.
- RESP: fwd_valid=1 until fwd_retry=0, then go to IDLE.
- MREQ: req_valid=1 with the latched VPN until accepted, then go to MWAIT.
- MWAIT:
  - ack_retry=0 and snoop_retry=0. Snoop has priority over ack.
  - On ack transfer, fill the victim entry: VPN=latched, PPN=ack_ppn, valid=1.
  - The response reports the victim index and ack_ppn; fwd_valid rises the next cycle (state RESP).
  - If the victim was valid, raise cmd_valid with the victim index alongside the fwd response. Leave RESP only when both fwd and cmd have transferred.
- Victim selection:
  - Lowest-index invalid entry.
  - If none, the entry at the round-robin pointer, which then increments mod ENTRIES (wraps ENTRIES-1 to 0).
- Snoop accepted in IDLE or MWAIT:
  - Store the return state. Search by VPN.
  - Hit: clear the valid bit that cycle, go to SCMD. cmd_valid=1 with the index until accepted, then go to SACK.
  - Miss: go straight to SACK.
- SACK: sack_valid=1 until accepted, then return to the saved state (IDLE or MWAIT).
- A snoop in MWAIT whose VPN equals the pending miss VPN does not cancel the miss; the subsequent ack fill still occurs.
- ack_retry=1 outside MWAIT. snoop_retry=1 outside IDLE/MWAIT. pc_retry=1 outside IDLE.
- Reset mid-operation:
  - Abandons any miss or snoop in progress. All entries are invalidated and no cmd is issued.
  - The L2 TLB is reset in the same cycle; stale acks are not expected.
- A VPN is never resident in two entries: fills only occur after a miss, and snoops only clear entries.

Optional Feature:
- Macro ICTLB_PREFETCH_EN adds ports pfetol1tlb_req_valid (in 1), pfetol1tlb_req_retry (out 1) and pfetol1tlb_req_vpn (in VPN_W).
- With the macro:
  - In IDLE with no snoop or pc valid, a prefetch is accepted and looked up.
  - Hit: dropped, back to IDLE.
  - Miss: goes through MREQ/MWAIT and fills as normal, but RESP asserts no fwd_valid; only the eviction cmd is sent if needed.
  - pfetol1tlb_req_retry=1 whenever a pc or snoop is valid or the FSM is not in IDLE.
- Without the macro: the ports are absent and there is no prefetch logic.

Test Plan:
- Reset, then pc VPN 0x12345 -> req_vpn=0x12345. Ack ppn 0xABCDE -> fwd ppn=0xABCDE, idx=0 one cycle after the ack. Repeat the lookup -> hit, fwd one cycle after acceptance, no L2 request.
- Fill all 16 entries (VPNs 0..15), then lookup VPN 16 -> victim idx 0, cmd_idx=0. Lookup VPN 17 -> victim idx 1 (pointer advanced).
- Hold fwd_retry=1 for 5 cycles on a hit -> fwd_valid and payload stable, pc_retry=1 throughout, transfer on the 6th cycle.
- Snoop VPN 3 when resident at idx 3 -> cmd_idx=3, then sack. Later lookup of VPN 3 misses. Snoop of a non-resident VPN -> sack only, no cmd.
- Snoop arrives during MWAIT -> snoop serviced with cmd and sack, FSM returns to MWAIT, then the ack fill completes with the correct fwd.
- Assert reset while in MWAIT -> all valid outputs 0 the next cycle. A following lookup of a previously filled VPN misses.
